// File: rtl/neo_port_master.sv
// ============================================================================
// neo_port_master : req/ack initiator for 68K P2 port read/write cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module neo_port_master #(
  parameter int SETUP  = 2,
  parameter int STROBE = 4,
  parameter int HOLD   = 1
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  BE,
  input  logic [18:0] ADDR,
  input  logic [15:0] WDATA,
  output logic        ACK,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        BUS_EN,
  output logic [18:0] M68K_ADDR,
  inout  wire  [15:0] M68K_DATA,
  output logic        nPORTOEL,
  output logic        nPORTOEU,
  output logic        nPORTWEL,
  output logic        nPORTWEU
);

  if (SETUP < 1 || SETUP > 15) begin : g_bad_setup
    $error("SETUP must be 1..15");
  end
  if (STROBE < 1 || STROBE > 15) begin : g_bad_strobe
    $error("STROBE must be 1..15");
  end
  if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
    $error("HOLD must be 1..15");
  end

  localparam logic [3:0] c_setup_ld  = 4'(SETUP - 1);
  localparam logic [3:0] c_strobe_ld = 4'(STROBE - 1);
  localparam logic [3:0] c_hold_ld   = 4'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_load;

  logic        r_we;
  logic [1:0]  r_be;
  logic [15:0] r_wdata;
  logic [18:0] r_addr;
  logic        r_drv;
  logic        r_ack;
  logic        r_busy;
  logic        r_bus_en;
  logic        r_noel;
  logic        r_noeu;
  logic        r_nwel;
  logic        r_nweu;
  logic [15:0] r_rdata;

  logic        w_bus_phase;
  logic        w_strobe;
  logic        w_we_eff;
  logic        w_capture;

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= w_load;
      else if (r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 4'd0;
    case (r_state)
      S_IDLE:   if (REQ)           w_next = S_SETUP;
      S_SETUP:  if (r_cnt == 4'd0) w_next = S_STROBE;
      S_STROBE: if (r_cnt == 4'd0) w_next = S_HOLD;
      S_HOLD:   if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:                      w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
    case (w_next)
      S_SETUP:  w_load = c_setup_ld;
      S_STROBE: w_load = c_strobe_ld;
      S_HOLD:   w_load = c_hold_ld;
      default:  w_load = 4'd0;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly at the
  // same edge as the state; WE is taken live only on the IDLE->SETUP edge.
  assign w_bus_phase = (w_next == S_SETUP) || (w_next == S_STROBE) || (w_next == S_HOLD);
  assign w_strobe    = (w_next == S_STROBE);
  assign w_we_eff    = (r_state == S_IDLE) ? WE : r_we;
  assign w_capture   = (r_state == S_STROBE) && (w_next == S_HOLD) && !r_we;

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      r_we     <= 1'b0;
      r_be     <= 2'b00;
      r_wdata  <= 16'h0000;
      r_addr   <= 19'h0;
      r_drv    <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_bus_en <= 1'b0;
      r_noel   <= 1'b1;
      r_noeu   <= 1'b1;
      r_nwel   <= 1'b1;
      r_nweu   <= 1'b1;
      r_rdata  <= 16'h0000;
    end else begin
      if (r_state == S_IDLE && REQ) begin
        r_we    <= WE;
        r_be    <= BE;
        r_wdata <= WDATA;
        r_addr  <= ADDR;
      end
      r_drv    <= w_bus_phase && w_we_eff;
      r_ack    <= (w_next == S_DONE);
      r_busy   <= (w_next != S_IDLE);
      r_bus_en <= w_bus_phase;
      r_noel   <= !(w_strobe && !r_we && r_be[0]);
      r_noeu   <= !(w_strobe && !r_we && r_be[1]);
      r_nwel   <= !(w_strobe &&  r_we && r_be[0]);
      r_nweu   <= !(w_strobe &&  r_we && r_be[1]);
      if (w_capture)
        r_rdata <= {(r_be[1] ? M68K_DATA[15:8] : 8'h00),
                    (r_be[0] ? M68K_DATA[7:0]  : 8'h00)};
    end
  end

  assign M68K_DATA = r_drv ? r_wdata : 16'hzzzz;
  assign M68K_ADDR = r_addr;
  assign ACK       = r_ack;
  assign BUSY      = r_busy;
  assign BUS_EN    = r_bus_en;
  assign RDATA     = r_rdata;
  assign nPORTOEL  = r_noel;
  assign nPORTOEU  = r_noeu;
  assign nPORTWEL  = r_nwel;
  assign nPORTWEU  = r_nweu;

endmodule

`default_nettype wire

// File: tb/tb_neo_port_master.sv
// ============================================================================
// tb_neo_port_master : directed self-checking bench for neo_port_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_neo_port_master;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic        i_we;
  logic [1:0]  i_be;
  logic [18:0] i_addr;
  logic [15:0] i_wdata;
  logic        o_ack;
  logic [15:0] o_rdata;
  logic        o_busy;
  logic        o_bus_en;
  logic [18:0] o_maddr;
  wire  [15:0] w_bus;
  logic        o_noel, o_noeu, o_nwel, o_nweu;

  logic        f_req;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        f_busy;
  logic        f_bus_en;
  logic [18:0] f_maddr;
  wire  [15:0] w_fbus;
  logic        f_noel, f_noeu, f_nwel, f_nweu;

  logic [15:0] r_resp;
  logic [15:0] r_exp_rdata;
  int          n_tests;
  int          n_fail;

  // Cartridge responder: drives the word while either read strobe is low.
  assign w_bus = (!o_noel || !o_noeu) ? r_resp : 16'hzzzz;

  neo_port_master u_dut (
    .CLK_24M(clk), .nRESET(rst_n), .REQ(i_req), .WE(i_we), .BE(i_be),
    .ADDR(i_addr), .WDATA(i_wdata), .ACK(o_ack), .RDATA(o_rdata),
    .BUSY(o_busy), .BUS_EN(o_bus_en), .M68K_ADDR(o_maddr), .M68K_DATA(w_bus),
    .nPORTOEL(o_noel), .nPORTOEU(o_noeu), .nPORTWEL(o_nwel), .nPORTWEU(o_nweu)
  );

  neo_port_master #(.SETUP(1), .STROBE(1), .HOLD(1)) u_dut_fast (
    .CLK_24M(clk), .nRESET(rst_n), .REQ(f_req), .WE(1'b1), .BE(2'b11),
    .ADDR(19'h01234), .WDATA(16'hBEEF), .ACK(f_ack), .RDATA(f_rdata),
    .BUSY(f_busy), .BUS_EN(f_bus_en), .M68K_ADDR(f_maddr), .M68K_DATA(w_fbus),
    .nPORTOEL(f_noel), .nPORTOEU(f_noeu), .nPORTWEL(f_nwel), .nPORTWEU(f_nweu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_idle(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // One request at default timing; checks every output in cycles 1..9.
  task automatic do_txn(input string nm, input logic we, input logic [1:0] be,
                        input logic [18:0] addr, input logic [15:0] wd,
                        input logic [15:0] resp);
    logic [15:0] new_rd;
    logic        stb, act;
    string       t;
    @(posedge clk); #1;
    i_req = 1'b1; i_we = we; i_be = be; i_addr = addr; i_wdata = wd; r_resp = resp;
    @(posedge clk); #1;
    i_req = 1'b0; i_we = ~we; i_be = ~be; i_addr = ~addr; i_wdata = ~wd;
    new_rd = we ? r_exp_rdata :
             {(be[1] ? resp[15:8] : 8'h00), (be[0] ? resp[7:0] : 8'h00)};
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      stb = (c >= 3) && (c <= 6);
      act = (c <= 7);
      t = $sformatf("%s c%0d", nm, c);
      check({t, " strobes"}, {o_noeu, o_noel, o_nweu, o_nwel},
            {!(!we && be[1] && stb), !(!we && be[0] && stb),
             !( we && be[1] && stb), !( we && be[0] && stb)});
      check({t, " ack"},    o_ack,    (c == 8));
      check({t, " bus_en"}, o_bus_en, act);
      check({t, " busy"},   o_busy,   (c <= 8));
      if (act) check({t, " addr"}, o_maddr, addr);
      if (we && act)
        check({t, " data"}, w_bus, wd);
      else if (!we && stb && be != 2'b00)
        check({t, " data"}, w_bus, resp);
      else
        check({t, " data_z"}, bus_idle(w_bus), 1'b1);
      check({t, " rdata"}, o_rdata, (c >= 7) ? new_rd : r_exp_rdata);
    end
    r_exp_rdata = new_rd;
  endtask

  initial begin
    int n_ack;
    string t;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_be = 2'b00;
    i_addr = '0; i_wdata = '0; r_resp = '0; f_req = 1'b0; r_exp_rdata = 16'h0000;

    #12;
    check("rst ack",     o_ack, 1'b0);
    check("rst busy",    o_busy, 1'b0);
    check("rst bus_en",  o_bus_en, 1'b0);
    check("rst rdata",   o_rdata, 16'h0000);
    check("rst addr",    o_maddr, 19'h0);
    check("rst strobes", {o_noeu, o_noel, o_nweu, o_nwel}, 4'hF);
    check("rst data_z",  bus_idle(w_bus), 1'b1);
    @(negedge clk); rst_n = 1'b1;

    do_txn("wr_word",  1'b1, 2'b11, 19'h7FFF8, 16'h1234, 16'h0000);
    do_txn("rd_word",  1'b0, 2'b11, 19'h7F223, 16'h1234, 16'h9A37);
    do_txn("wr_hold",  1'b1, 2'b10, 19'h00ABC, 16'h5AA5, 16'h0000);
    do_txn("rd_byteL", 1'b0, 2'b01, 19'h00010, 16'h0000, 16'hABCD);
    do_txn("rd_byteU", 1'b0, 2'b10, 19'h00020, 16'h0000, 16'hABCD);
    do_txn("rd_be00",  1'b0, 2'b00, 19'h00030, 16'h0000, 16'hFFFF);
    do_txn("wr_be00",  1'b1, 2'b00, 19'h00040, 16'h8001, 16'h0000);

    // Back-to-back: REQ held across the first ACK
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b1; i_be = 2'b11; i_addr = 19'h10000; i_wdata = 16'h5555;
    @(posedge clk); #1;
    i_addr = 19'h00123; i_wdata = 16'hAAAA;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      t = $sformatf("b2b c%0d", c);
      check({t, " ack"}, o_ack, (c == 8) || (c == 17));
      if (c == 5) check({t, " addr"}, o_maddr, 19'h10000);
      if (c == 5) check({t, " data"}, w_bus, 16'h5555);
      if (c == 9) check({t, " bus_en"}, o_bus_en, 1'b0);
      if (c == 9) check({t, " busy"}, o_busy, 1'b0);
      if (c == 10) begin
        check({t, " bus_en"}, o_bus_en, 1'b1);
        check({t, " addr"}, o_maddr, 19'h00123);
        check({t, " data"}, w_bus, 16'hAAAA);
        i_req = 1'b0;
      end
      if (c == 12) check({t, " strobes"}, {o_nweu, o_nwel}, 2'b00);
    end

    // Reset pulse during cycle 4 of a write
    @(posedge clk); #1;
    i_req = 1'b1; i_we = 1'b1; i_be = 2'b11; i_addr = 19'h2AAAA; i_wdata = 16'hC3C3;
    @(posedge clk); #1;
    i_req = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    check("rstmid pre strobes", {o_nweu, o_nwel}, 2'b00);
    check("rstmid pre data", w_bus, 16'hC3C3);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid strobes", {o_noeu, o_noel, o_nweu, o_nwel}, 4'hF);
    check("rstmid data_z",  bus_idle(w_bus), 1'b1);
    check("rstmid bus_en",  o_bus_en, 1'b0);
    check("rstmid busy",    o_busy, 1'b0);
    check("rstmid rdata",   o_rdata, 16'h0000);
    r_exp_rdata = 16'h0000;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    n_ack = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_ack || o_busy) n_ack++;
    end
    check("rstmid no_ack", n_ack, 0);
    do_txn("post_rst", 1'b1, 2'b11, 19'h05555, 16'h0F0F, 16'h0000);
    do_txn("post_rd",  1'b0, 2'b11, 19'h05556, 16'h0000, 16'h7E81);

    // Minimum timing instance: SETUP=STROBE=HOLD=1
    @(posedge clk); #1 f_req = 1'b1;
    @(posedge clk); #1 f_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      t = $sformatf("fast c%0d", c);
      check({t, " strobes"}, {f_noeu, f_noel, f_nweu, f_nwel},
            (c == 2) ? 4'hC : 4'hF);
      check({t, " ack"}, f_ack, (c == 4));
      check({t, " bus_en"}, f_bus_en, (c <= 3));
      if (c <= 3) check({t, " data"}, w_fbus, 16'hBEEF);
      if (c <= 3) check({t, " addr"}, f_maddr, 19'h01234);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/neo_port_master.md
# neo_port_master

Bus-cycle initiator for the cartridge P2 port window ($200000–$2FFFFF). Converts a single-word req/ack request from an internal agent (save-state engine, debug poke, HPS-driven cartridge init) into a correctly timed 68K port read or write cycle on M68K_ADDR/M68K_DATA with nPORTOEL/U and nPORTWEL/U strobes. This is the driving end of the port interface that cartridge-side responders such as the SMA protection chip decode. It sits beside the 68K bus arbiter and only drives the bus while granted.

## Interface
Parameters:
- SETUP, 2, cycles address/data valid before strobe fall (1–15)
- STROBE, 4, cycles strobe held low (1–15)
- HOLD, 1, cycles address/data held after strobe rise (1–15)

Ports:
- CLK_24M  in  1  system clock
- nRESET  in  1  asynchronous, active-low reset
- REQ  in  1  request; sampled only in IDLE
- WE  in  1  1 = write, 0 = read
- BE  in  2  byte enables: [1] upper (D15:8), [0] lower (D7:0)
- ADDR  in  19  word address (M68K_ADDR[19:1])
- WDATA  in  16  write data
- ACK  out  1  one-cycle completion pulse
- RDATA  out  16  read data
- BUSY  out  1  high in any state except IDLE
- BUS_EN  out  1  high while address/strobes are owned (SETUP..HOLD)
- M68K_ADDR  out  19  port address
- M68K_DATA  inout  16  port data; driven only on writes
- nPORTOEL, nPORTOEU  out  1 each  read strobes, active low
- nPORTWEL, nPORTWEU  out  1 each  write strobes, active low

## Operation
- States: IDLE → SETUP → STROBE → HOLD → DONE → IDLE.
- IDLE: REQ=1 at a clock edge latches WE, BE, ADDR, WDATA; go to SETUP. Inputs ignored outside IDLE.
- SETUP: M68K_ADDR = latched ADDR, BUS_EN=1; on writes M68K_DATA driven with latched WDATA. Runs SETUP cycles.
- STROBE: for each set BE bit the matching strobe is low (OE for reads, WE for writes). Runs STROBE cycles. BE=00 runs the full sequence with no strobe asserted and still ACKs.
- HOLD: strobes high; address and write data held. Runs HOLD cycles.
- DONE: ACK=1 for exactly one cycle, BUS_EN=0, bus released; then IDLE. The requester deasserts REQ on seeing ACK. REQ still high in the following IDLE cycle starts a new cycle.
- Read capture: at the edge leaving the last STROBE cycle, RDATA lanes with BE set load M68K_DATA; lanes with BE clear load 8'h00. RDATA holds until the next read capture. Writes do not change RDATA.
- M68K_DATA is Z in IDLE, DONE and throughout every read cycle.
- Counter: one 4-bit down-counter reloaded on each state entry. Parameter value 0 is illegal (synthesis assertion).

## Timing
- All outputs are registered; strobes are glitch-free.
- Reset values: ACK=0, BUSY=0, BUS_EN=0, RDATA=0, M68K_ADDR=0, all four strobes=1, M68K_DATA=Z, state=IDLE.
- Reset mid-cycle: strobes rise and the bus is released asynchronously. No ACK. The aborted request is discarded.
- Latency: REQ sampled at edge 0 → ACK high in cycle SETUP+STROBE+HOLD+1. With defaults: SETUP cycles 1–2, strobe low cycles 3–6, HOLD cycle 7, ACK in cycle 8.
- Minimum repeat period: SETUP+STROBE+HOLD+2 cycles (9 at defaults).
- The strobe-rise edge of a write is the responder's capture edge. Address and data stay stable ≥ HOLD cycles after it.

## Test plan
- Write word: ADDR='h7FFF8, WDATA='h1234, BE=11 → nPORTWEL/U low in cycles 3–6 only, M68K_DATA='h1234 in cycles 1–7, ACK in cycle 8, OE strobes stay high.
- Read with responder model returning 'h9A37 at ADDR='h7F223, BE=11 → nPORTOEL/U low in cycles 3–6, RDATA='h9A37 from cycle 7, M68K_DATA never driven by the DUT.
- Byte read BE=01, bus='hABCD → only nPORTOEL toggles, RDATA='h00CD. BE=00 → no strobes, ACK still in cycle 8.
- Back-to-back: REQ held high across ACK → second cycle's SETUP starts in cycle 10, two ACKs 9 cycles apart.
- Reset pulse in cycle 4 of a write → all strobes high and M68K_DATA Z immediately, no ACK, next request completes normally.
- Parameters SETUP=1, STROBE=1, HOLD=1 → strobe low for exactly cycle 2, ACK in cycle 4.
